control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 54 +++++
 rtl/step_counter.sv | 64 ++++++
 rtl/control_unit.sv | 163 ++++++++++++++++
 tb/tb_control_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the microcoded 8-bit CPU: opcodes, T-step indices,
// control-word bit positions and the sequencer state encoding.
package cpu_pkg;

   // Instruction opcodes (instruction register bits [7:4])
   typedef enum logic [3:0] {
      OP_NOP = 4'b0000,
      OP_LDA = 4'b0001,
      OP_ADD = 4'b0010,
      OP_SUB = 4'b0011,
      OP_STA = 4'b0100,
      OP_LDI = 4'b0101,
      OP_JMP = 4'b0110,
      OP_JC  = 4'b0111,
      OP_JZ  = 4'b1000,
      OP_OUT = 4'b1110,
      OP_HLT = 4'b1111
   } opcode_e;

   // T-step indices
   localparam logic [2:0] T0       = 3'd0;
   localparam logic [2:0] T1       = 3'd1;
   localparam logic [2:0] T2       = 3'd2;
   localparam logic [2:0] T3       = 3'd3;
   localparam logic [2:0] T4       = 3'd4;
   localparam logic [2:0] STEP_MAX = T4;

   // Control-word bit positions
   localparam int CW_W          = 15;
   localparam int CW_PC_INC     = 0;
   localparam int CW_PC_LOAD    = 1;
   localparam int CW_PC_OUT     = 2;
   localparam int CW_MAR_LOAD   = 3;
   localparam int CW_RAM_OUT    = 4;
   localparam int CW_RAM_IN     = 5;
   localparam int CW_IR_LOAD    = 6;
   localparam int CW_IR_OUT     = 7;
   localparam int CW_A_LOAD     = 8;
   localparam int CW_A_OUT      = 9;
   localparam int CW_B_LOAD     = 10;
   localparam int CW_ALU_OUT    = 11;
   localparam int CW_ALU_SUB    = 12;
   localparam int CW_FLAGS_LOAD = 13;
   localparam int CW_OUT_LOAD   = 14;

   typedef logic [CW_W-1:0] ctrl_word_t;

   // Sequencer state
   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } seq_state_e;

endpackage

// File: rtl/step_counter.sv
// T-step sequencer: counts 0..4, holds when not enabled, wraps on the last
// step of an instruction and latches the halted condition until reset.
module step_counter
   import cpu_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_step_en,
   input  logic       i_last,
   input  logic       i_halt_req,
   output logic [2:0] o_step,
   output logic       o_halted
);

   seq_state_e r_state;
   seq_state_e w_state_nxt;
   logic [2:0] r_step;
   logic [2:0] w_step_nxt;

   // State register: synchronous reset clears both step and halted
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_RUN;
         r_step  <= T0;
      end else begin
         r_state <= w_state_nxt;
         r_step  <= w_step_nxt;
      end
   end

   // Next-state logic: hold, advance, wrap, or enter HALTED
   always_comb begin
      w_state_nxt = r_state;
      w_step_nxt  = r_step;
      case (r_state)
         ST_RUN: begin
            if (i_step_en) begin
               if (i_halt_req) begin
                  w_state_nxt = ST_HALTED;
                  w_step_nxt  = T0;
               end else if (i_last || (r_step >= STEP_MAX)) begin
                  w_step_nxt = T0;
               end else begin
                  w_step_nxt = r_step + 3'd1;
               end
            end
         end
         ST_HALTED: begin
            w_step_nxt = T0;
         end
         default: begin
            w_state_nxt = ST_RUN;
            w_step_nxt  = T0;
         end
      endcase
   end

   // Outputs: current step and halted flag
   always_comb begin
      o_step   = r_step;
      o_halted = (r_state == ST_HALTED);
   end

endmodule

// File: rtl/control_unit.sv
// Microcode control unit: decodes (step, opcode, flags) into the datapath
// control word and drives the step sequencer.
module control_unit
   import cpu_pkg::*;
#(
   parameter bit HALT_ON_UNKNOWN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       step_en,
   input  logic [3:0] opcode,
   input  logic       flag_c,
   input  logic       flag_z,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       pc_out,
   output logic       mar_load,
   output logic       ram_out,
   output logic       ram_in,
   output logic       ir_load,
   output logic       ir_out,
   output logic       a_load,
   output logic       a_out,
   output logic       b_load,
   output logic       alu_out,
   output logic       alu_sub,
   output logic       flags_load,
   output logic       out_load,
   output logic [2:0] step,
   output logic       halted
);

   logic [2:0] w_step;
   logic       w_halted;
   logic       w_last;
   logic       w_halt_req;
   logic       w_active;
   ctrl_word_t w_cw;
   ctrl_word_t w_ctrl;

   step_counter u_step_counter (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_step_en  (step_en),
      .i_last     (w_last),
      .i_halt_req (w_halt_req),
      .o_step     (w_step),
      .o_halted   (w_halted)
   );

   // Microcode decode: raw control word plus end-of-instruction and halt requests
   always_comb begin
      w_cw       = '0;
      w_last     = 1'b0;
      w_halt_req = 1'b0;
      case (w_step)
         T0: begin
            w_cw[CW_PC_OUT]   = 1'b1;
            w_cw[CW_MAR_LOAD] = 1'b1;
         end
         T1: begin
            w_cw[CW_RAM_OUT]  = 1'b1;
            w_cw[CW_IR_LOAD]  = 1'b1;
            w_cw[CW_PC_INC]   = 1'b1;
         end
         T2: begin
            case (opcode)
               OP_NOP: w_last = 1'b1;
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  w_cw[CW_IR_OUT]   = 1'b1;
                  w_cw[CW_MAR_LOAD] = 1'b1;
               end
               OP_LDI: begin
                  w_cw[CW_IR_OUT] = 1'b1;
                  w_cw[CW_A_LOAD] = 1'b1;
                  w_last          = 1'b1;
               end
               OP_JMP: begin
                  w_cw[CW_IR_OUT]  = 1'b1;
                  w_cw[CW_PC_LOAD] = 1'b1;
                  w_last           = 1'b1;
               end
               OP_JC: begin
                  w_cw[CW_IR_OUT]  = 1'b1;
                  w_cw[CW_PC_LOAD] = flag_c;
                  w_last           = 1'b1;
               end
               OP_JZ: begin
                  w_cw[CW_IR_OUT]  = 1'b1;
                  w_cw[CW_PC_LOAD] = flag_z;
                  w_last           = 1'b1;
               end
               OP_OUT: begin
                  w_cw[CW_A_OUT]    = 1'b1;
                  w_cw[CW_OUT_LOAD] = 1'b1;
                  w_last            = 1'b1;
               end
               OP_HLT: w_halt_req = 1'b1;
               default: begin
                  // Undefined opcodes either stop the machine or fall through as NOP
                  w_halt_req = HALT_ON_UNKNOWN;
                  w_last     = ~HALT_ON_UNKNOWN;
               end
            endcase
         end
         T3: begin
            // Ops that do not reach T3 wrap defensively back to fetch
            w_last = 1'b1;
            case (opcode)
               OP_LDA: begin
                  w_cw[CW_RAM_OUT] = 1'b1;
                  w_cw[CW_A_LOAD]  = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  w_cw[CW_RAM_OUT] = 1'b1;
                  w_cw[CW_B_LOAD]  = 1'b1;
                  w_last           = 1'b0;
               end
               OP_STA: begin
                  w_cw[CW_A_OUT]  = 1'b1;
                  w_cw[CW_RAM_IN] = 1'b1;
               end
               default: ;
            endcase
         end
         T4: begin
            w_last = 1'b1;
            if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
               w_cw[CW_ALU_OUT]    = 1'b1;
               w_cw[CW_A_LOAD]     = 1'b1;
               w_cw[CW_FLAGS_LOAD] = 1'b1;
               w_cw[CW_ALU_SUB]    = (opcode == OP_SUB);
            end
         end
         default: w_last = 1'b1;
      endcase
   end

   // Gate the control word: nothing drives while in reset, paused or halted
   always_comb begin
      w_active = ~rst & step_en & ~w_halted;
      w_ctrl   = w_cw & {CW_W{w_active}};
   end

   assign pc_inc     = w_ctrl[CW_PC_INC];
   assign pc_load    = w_ctrl[CW_PC_LOAD];
   assign pc_out     = w_ctrl[CW_PC_OUT];
   assign mar_load   = w_ctrl[CW_MAR_LOAD];
   assign ram_out    = w_ctrl[CW_RAM_OUT];
   assign ram_in     = w_ctrl[CW_RAM_IN];
   assign ir_load    = w_ctrl[CW_IR_LOAD];
   assign ir_out     = w_ctrl[CW_IR_OUT];
   assign a_load     = w_ctrl[CW_A_LOAD];
   assign a_out      = w_ctrl[CW_A_OUT];
   assign b_load     = w_ctrl[CW_B_LOAD];
   assign alu_out    = w_ctrl[CW_ALU_OUT];
   assign alu_sub    = w_ctrl[CW_ALU_SUB];
   assign flags_load = w_ctrl[CW_FLAGS_LOAD];
   assign out_load   = w_ctrl[CW_OUT_LOAD];
   assign step       = w_step;
   assign halted     = w_halted;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: fetch/execute words per opcode, jumps on
// flags, pause, halt and mid-instruction reset.
module tb_control_unit;
   import cpu_pkg::*;

   logic       clk = 1'b0;
   logic       rst, step_en, flag_c, flag_z;
   logic [3:0] opcode;
   logic       pc_inc, pc_load, pc_out, mar_load, ram_out, ram_in, ir_load;
   logic       ir_out, a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load;
   logic [2:0] step;
   logic       halted;

   int n_checks = 0;
   int n_fail   = 0;

   // Bench-side view of the outputs, fixed order independent of the RTL packing
   localparam logic [14:0] B_PC_INC     = 15'h4000;
   localparam logic [14:0] B_PC_LOAD    = 15'h2000;
   localparam logic [14:0] B_PC_OUT     = 15'h1000;
   localparam logic [14:0] B_MAR_LOAD   = 15'h0800;
   localparam logic [14:0] B_RAM_OUT    = 15'h0400;
   localparam logic [14:0] B_RAM_IN     = 15'h0200;
   localparam logic [14:0] B_IR_LOAD    = 15'h0100;
   localparam logic [14:0] B_IR_OUT     = 15'h0080;
   localparam logic [14:0] B_A_LOAD     = 15'h0040;
   localparam logic [14:0] B_A_OUT      = 15'h0020;
   localparam logic [14:0] B_B_LOAD     = 15'h0010;
   localparam logic [14:0] B_ALU_OUT    = 15'h0008;
   localparam logic [14:0] B_ALU_SUB    = 15'h0004;
   localparam logic [14:0] B_FLAGS_LOAD = 15'h0002;
   localparam logic [14:0] B_OUT_LOAD   = 15'h0001;
   localparam logic [14:0] W_T0 = B_PC_OUT | B_MAR_LOAD;
   localparam logic [14:0] W_T1 = B_RAM_OUT | B_IR_LOAD | B_PC_INC;

   logic [14:0] cw;
   assign cw = {pc_inc, pc_load, pc_out, mar_load, ram_out, ram_in, ir_load,
                ir_out, a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load};

   control_unit #(.HALT_ON_UNKNOWN(1'b1)) dut (
      .clk(clk), .rst(rst), .step_en(step_en), .opcode(opcode),
      .flag_c(flag_c), .flag_z(flag_z),
      .pc_inc(pc_inc), .pc_load(pc_load), .pc_out(pc_out), .mar_load(mar_load),
      .ram_out(ram_out), .ram_in(ram_in), .ir_load(ir_load), .ir_out(ir_out),
      .a_load(a_load), .a_out(a_out), .b_load(b_load), .alu_out(alu_out),
      .alu_sub(alu_sub), .flags_load(flags_load), .out_load(out_load),
      .step(step), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Check step, full control word and the two exclusivity properties
   task automatic expect_cycle(input string tag, input logic [2:0] st, input logic [14:0] w);
      int drivers;
      #1;
      drivers = int'(pc_out) + int'(ram_out) + int'(ir_out) + int'(a_out) + int'(alu_out);
      check({tag, "_step"}, 32'(step), 32'(st));
      check({tag, "_ctrl"}, 32'(cw), 32'(w));
      check({tag, "_bus1"}, 32'(drivers <= 1), 32'd1);
      check({tag, "_incld"}, 32'(pc_inc & pc_load), 32'd0);
   endtask

   task automatic fetch(input string tag);
      expect_cycle({tag, "_t0"}, T0, W_T0);
      cyc();
      expect_cycle({tag, "_t1"}, T1, W_T1);
      cyc();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   logic [3:0]  op3_tab [4];
   logic [14:0] w3_tab  [4];

   initial begin
      rst = 1'b1; step_en = 1'b1; opcode = OP_LDI; flag_c = 1'b0; flag_z = 1'b0;
      cyc();
      cyc();
      #1;
      check("rst_step", 32'(step), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_ctrl", 32'(cw), 32'd0);
      rst = 1'b0;

      // LDI
      fetch("ldi");
      expect_cycle("ldi_t2", T2, B_IR_OUT | B_A_LOAD);
      cyc();
      expect_cycle("ldi_wrap", T0, W_T0);

      // ADD then SUB
      for (int s = 0; s < 2; s++) begin
         opcode = (s == 0) ? OP_ADD : OP_SUB;
         fetch("alu");
         expect_cycle("alu_t2", T2, B_IR_OUT | B_MAR_LOAD);
         cyc();
         expect_cycle("alu_t3", T3, B_RAM_OUT | B_B_LOAD);
         cyc();
         expect_cycle("alu_t4", T4, B_ALU_OUT | B_A_LOAD | B_FLAGS_LOAD | ((s == 1) ? B_ALU_SUB : 15'h0));
         cyc();
         expect_cycle("alu_wrap", T0, W_T0);
      end

      // LDA and STA (4 steps)
      opcode = OP_LDA;
      fetch("lda");
      expect_cycle("lda_t2", T2, B_IR_OUT | B_MAR_LOAD);
      cyc();
      expect_cycle("lda_t3", T3, B_RAM_OUT | B_A_LOAD);
      cyc();
      opcode = OP_STA;
      fetch("sta");
      expect_cycle("sta_t2", T2, B_IR_OUT | B_MAR_LOAD);
      cyc();
      expect_cycle("sta_t3", T3, B_A_OUT | B_RAM_IN);
      cyc();

      // Three-step instructions
      op3_tab[0] = OP_NOP; w3_tab[0] = 15'h0;
      op3_tab[1] = OP_JMP; w3_tab[1] = B_IR_OUT | B_PC_LOAD;
      op3_tab[2] = OP_OUT; w3_tab[2] = B_A_OUT | B_OUT_LOAD;
      op3_tab[3] = OP_LDI; w3_tab[3] = B_IR_OUT | B_A_LOAD;
      for (int i = 0; i < 4; i++) begin
         opcode = op3_tab[i];
         fetch("op3");
         expect_cycle("op3_t2", T2, w3_tab[i]);
         cyc();
      end

      // Conditional jumps on each flag value
      for (int f = 0; f < 2; f++) begin
         opcode = OP_JC; flag_c = f[0]; flag_z = ~f[0];
         fetch("jc");
         expect_cycle("jc_t2", T2, B_IR_OUT | (f[0] ? B_PC_LOAD : 15'h0));
         cyc();
         opcode = OP_JZ; flag_z = f[0]; flag_c = ~f[0];
         fetch("jz");
         expect_cycle("jz_t2", T2, B_IR_OUT | (f[0] ? B_PC_LOAD : 15'h0));
         cyc();
      end
      flag_c = 1'b0; flag_z = 1'b0;

      // Pause mid-ADD at T3
      opcode = OP_ADD;
      fetch("pause");
      expect_cycle("pause_t2", T2, B_IR_OUT | B_MAR_LOAD);
      cyc();
      step_en = 1'b0;
      expect_cycle("pause_hold0", T3, 15'h0);
      for (int k = 0; k < 4; k++) begin
         cyc();
         expect_cycle("pause_hold", T3, 15'h0);
      end
      step_en = 1'b1;
      expect_cycle("pause_t3", T3, B_RAM_OUT | B_B_LOAD);
      cyc();
      expect_cycle("pause_t4", T4, B_ALU_OUT | B_A_LOAD | B_FLAGS_LOAD);
      cyc();
      expect_cycle("pause_wrap", T0, W_T0);

      // Reset at T3 of STA
      opcode = OP_STA;
      fetch("starst");
      cyc();
      expect_cycle("starst_t3", T3, B_A_OUT | B_RAM_IN);
      rst = 1'b1;
      expect_cycle("starst_inrst", T3, 15'h0);
      cyc();
      rst = 1'b0;
      expect_cycle("starst_after", T0, W_T0);
      check("starst_ramin", 32'(ram_in), 32'd0);

      // HLT
      opcode = OP_HLT;
      fetch("hlt");
      expect_cycle("hlt_t2", T2, 15'h0);
      check("hlt_pre", 32'(halted), 32'd0);
      cyc();
      for (int k = 0; k < 20; k++) begin
         expect_cycle("hlt_hold", T0, 15'h0);
         check("hlt_flag", 32'(halted), 32'd1);
         cyc();
      end
      do_reset();
      expect_cycle("hlt_rst", T0, W_T0);
      check("hlt_rst_flag", 32'(halted), 32'd0);

      // Undefined opcode halts at T2
      opcode = 4'b1011;
      fetch("undef");
      expect_cycle("undef_t2", T2, 15'h0);
      cyc();
      check("undef_halt", 32'(halted), 32'd1);
      expect_cycle("undef_hold", T0, 15'h0);
      do_reset();
      check("undef_rst", 32'(halted), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
